mem_line_responder: RTL and testbench



---
 rtl/mem_line_if.sv | 29 ++
 rtl/mem_line_responder.sv | 114 +++++++++++
 tb/tb_mem_line_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_if.sv
// rtl/mem_line_if.sv - request/beat handshake bundle between cache controller and line responder
interface mem_line_if #(
  parameter int BLK_W  = 13,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [BLK_W-1:0]  req_blk;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              wr_done;
  logic              busy;

  modport master (
    output req_valid, req_write, req_blk, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
  );

  modport slave (
    input  req_valid, req_write, req_blk, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
  );
endinterface

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - backing store serving whole-line fills and writebacks
module mem_line_responder #(
  parameter int BLK_W  = 13,
  parameter int WORDS  = 16,
  parameter int DATA_W = 32,
  parameter int LAT    = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_line_if.slave bus
);
  localparam int              BW        = $clog2(WORDS);
  localparam int              DEPTH     = (2 ** BLK_W) * WORDS;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(WORDS - 1);
  localparam logic [3:0]      LAT_LOAD  = 4'(LAT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WBURST = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RBURST = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_nxt;
  logic [3:0]        cnt;
  logic [BLK_W-1:0]  blk;
  logic              is_write;
  logic [DATA_W-1:0] rdata_q;
  logic              w_hs;

  // Storage survives rst; only power-up zeroes it.
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  assign beat_nxt = beat + 1'b1;
  assign w_hs     = (state == WBURST) && bus.wdata_valid;

  always_ff @(posedge clk) begin
    if (w_hs) begin
      mem[{blk, beat}] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      cnt      <= '0;
      blk      <= '0;
      is_write <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            blk      <= bus.req_blk;
            is_write <= bus.req_write;
            if (bus.req_write) begin
              state <= WBURST;
            end else begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        WBURST: begin
          if (bus.wdata_valid) begin
            if (beat == LAST_BEAT) begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
              beat  <= '0;
            end else begin
              beat <= beat_nxt;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (is_write) begin
              state <= DONE;
            end else begin
              state   <= RBURST;
              rdata_q <= mem[{blk, beat}];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RBURST: begin
          // Prefetch the next word on acceptance so rdata stays registered.
          if (bus.rdata_ready) begin
            if (beat == LAST_BEAT) begin
              state <= IDLE;
              beat  <= '0;
            end else begin
              beat    <= beat_nxt;
              rdata_q <= mem[{blk, beat_nxt}];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.wdata_ready = (state == WBURST);
  assign bus.rdata_valid = (state == RBURST);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = (state == RBURST) && (beat == LAST_BEAT);
  assign bus.wr_done     = (state == DONE);
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - directed bench for mem_line_responder
module tb_mem_line_responder;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  mem_line_if #(.BLK_W(13), .DATA_W(32)) bus ();
  mem_line_if #(.BLK_W(13), .DATA_W(32)) bus1 ();
  mem_line_if #(.BLK_W(13), .DATA_W(32)) bus15 ();

  mem_line_responder #(.BLK_W(13), .WORDS(16), .DATA_W(32), .LAT(4))
    dut (.clk(clk), .rst(rst), .bus(bus));
  mem_line_responder #(.BLK_W(13), .WORDS(16), .DATA_W(32), .LAT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_line_responder #(.BLK_W(13), .WORDS(16), .DATA_W(32), .LAT(15))
    dut15 (.clk(clk), .rst(rst), .bus(bus15));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [31:0] stall_data [8];
  logic        stall_valid [8];
  logic        stall_lastf [8];
  int          rd_first;
  logic        rd_end_rr;
  int          hs_cyc;
  int          last_beat_cyc;
  int          wr_lat;
  logic        wr_after;
  logic        rr_after_wr;

  task automatic send_req(input logic wr, input logic [12:0] b);
    int t;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_blk   = b;
    t = 0;
    while (!bus.req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!bus.req_ready) begin
      $display("FAIL req_timeout got req_ready=0 want 1");
      errors++; checks++;
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [31:0] base, input int n, input bit gap);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.wdata_valid = 1'b0;
        bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
      end
      bus.wdata_valid = 1'b1;
      bus.wdata = base + 32'(i);
      t = 0;
      while (!bus.wdata_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!bus.wdata_ready) begin
        $display("FAIL wbeat_timeout beat %0d got wdata_ready=0 want 1", i);
        errors++; checks++;
      end
      @(posedge clk); #1;
      last_beat_cyc = cyc;
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic write_line(input logic [12:0] b, input logic [31:0] base, input bit gap);
    int t;
    send_req(1'b1, b);
    write_beats(base, 16, gap);
    t = 0;
    while (!bus.wr_done && t < 100) begin @(posedge clk); #1; t++; end
    wr_lat = cyc - last_beat_cyc;
    if (!bus.wr_done) wr_lat = -1;
    @(posedge clk); #1;
    wr_after    = bus.wr_done;
    rr_after_wr = bus.req_ready;
  endtask

  task automatic read_line(input int stall_at, input int stall_len);
    int t;
    rd_first = -1;
    bus.rdata_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t = 0;
      while (!bus.rdata_valid && t < 100) begin @(posedge clk); #1; t++; end
      if (!bus.rdata_valid) begin
        $display("FAIL read_timeout beat %0d got rdata_valid=0 want 1", i);
        errors++; checks++;
        bus.rdata_ready = 1'b0;
        return;
      end
      if (i == 0) rd_first = cyc;
      if (i == stall_at) begin
        bus.rdata_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          stall_data[s]  = bus.rdata;
          stall_valid[s] = bus.rdata_valid;
          stall_lastf[s] = bus.rdata_last;
        end
        bus.rdata_ready = 1'b1;
      end
      rd_data[i] = bus.rdata;
      rd_last[i] = bus.rdata_last;
      @(posedge clk); #1;
    end
    bus.rdata_ready = 1'b0;
    rd_end_rr = bus.req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.busy} !== 6'b100000) begin
      $display("FAIL reset_outputs got %b want 100000",
               {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.wr_done, bus.busy});
      errors++;
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      $display("FAIL reset_rdata got %h want 00000000", bus.rdata); errors++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_after_reset();
    send_req(1'b0, 13'h0005);
    read_line(-1, 0);
    checks++;
    if (rd_first - hs_cyc !== 4) begin
      $display("FAIL fill_latency got %0d want 4", rd_first - hs_cyc); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_last[i] !== (i == 15)) begin
        $display("FAIL fill_zero beat %0d got %h last %b want 00000000 last %b", i, rd_data[i], rd_last[i], i == 15);
        errors++;
      end
    end
    checks++;
    if (rd_end_rr !== 1'b1) begin
      $display("FAIL fill_req_ready got %b want 1", rd_end_rr); errors++;
    end
  endtask

  task automatic test_writeback_fill();
    write_line(13'h1ABC, 32'hA0000000, 1'b0);
    checks++;
    if (wr_lat !== 4) begin
      $display("FAIL wr_done_latency got %0d want 4", wr_lat); errors++;
    end
    checks++;
    if (wr_after !== 1'b0 || rr_after_wr !== 1'b1) begin
      $display("FAIL wr_done_pulse got wr_done=%b req_ready=%b want 0 1", wr_after, rr_after_wr); errors++;
    end
    send_req(1'b0, 13'h1ABC);
    read_line(-1, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== 32'hA0000000 + 32'(i)) begin
        $display("FAIL wb_fill beat %0d got %h want %h", i, rd_data[i], 32'hA0000000 + 32'(i)); errors++;
      end
    end
  endtask

  task automatic test_backpressure_gaps();
    send_req(1'b0, 13'h1ABC);
    read_line(7, 3);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (stall_data[s] !== 32'hA0000007 || stall_valid[s] !== 1'b1 || stall_lastf[s] !== 1'b0) begin
        $display("FAIL stall_hold cycle %0d got %h v%b l%b want a0000007 v1 l0",
                 s, stall_data[s], stall_valid[s], stall_lastf[s]);
        errors++;
      end
    end
    checks++;
    if (rd_data[7] !== 32'hA0000007 || rd_data[8] !== 32'hA0000008) begin
      $display("FAIL stall_resume got %h %h want a0000007 a0000008", rd_data[7], rd_data[8]); errors++;
    end
    write_line(13'h0033, 32'h55000000, 1'b1);
    checks++;
    if (wr_lat !== 4) begin
      $display("FAIL gap_wr_latency got %0d want 4", wr_lat); errors++;
    end
    send_req(1'b0, 13'h0033);
    read_line(-1, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== 32'h55000000 + 32'(i)) begin
        $display("FAIL gap_fill beat %0d got %h want %h", i, rd_data[i], 32'h55000000 + 32'(i)); errors++;
      end
    end
  endtask

  task automatic test_aliasing();
    write_line(13'h0010, 32'h11110000, 1'b0);
    write_line(13'h1010, 32'h22220000, 1'b0);
    send_req(1'b0, 13'h0010);
    read_line(-1, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== 32'h11110000 + 32'(i)) begin
        $display("FAIL alias_lo beat %0d got %h want %h", i, rd_data[i], 32'h11110000 + 32'(i)); errors++;
      end
    end
    send_req(1'b0, 13'h1010);
    read_line(-1, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== 32'h22220000 + 32'(i)) begin
        $display("FAIL alias_hi beat %0d got %h want %h", i, rd_data[i], 32'h22220000 + 32'(i)); errors++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int dones;
    write_line(13'h0002, 32'hB0000000, 1'b0);
    send_req(1'b1, 13'h0002);
    write_beats(32'hC0000000, 6, 1'b0);
    bus.wdata_valid = 1'b1;
    bus.wdata = 32'hC0000006;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.wr_done, bus.busy} !== 5'b10000) begin
      $display("FAIL async_reset got %b want 10000",
               {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.wr_done, bus.busy});
      errors++;
    end
    bus.wdata_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (8) begin @(posedge clk); #1; if (bus.wr_done) dones++; end
    checks++;
    if (dones !== 0) begin
      $display("FAIL reset_no_wr_done got %0d pulses want 0", dones); errors++;
    end
    send_req(1'b0, 13'h0002);
    read_line(-1, 0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      exp = (i < 6) ? 32'hC0000000 + 32'(i) : 32'hB0000000 + 32'(i);
      checks++;
      if (rd_data[i] !== exp) begin
        $display("FAIL partial_line beat %0d got %h want %h", i, rd_data[i], exp); errors++;
      end
    end
  endtask

  task automatic test_ignored_and_lat();
    int t;
    int h;
    send_req(1'b0, 13'h1ABC);
    t = 0;
    while (!bus.rdata_valid && t < 100) begin @(posedge clk); #1; t++; end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_blk   = 13'h0777;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.rdata_valid, bus.wdata_ready, bus.req_ready} !== 4'b1100) begin
      $display("FAIL ignored_req got %b want 1100", {bus.busy, bus.rdata_valid, bus.wdata_ready, bus.req_ready});
      errors++;
    end
    checks++;
    if (bus.rdata !== 32'hA0000000) begin
      $display("FAIL ignored_req_data got %h want a0000000", bus.rdata); errors++;
    end
    bus.rdata_ready = 1'b1;
    t = 0;
    while (bus.busy && t < 100) begin @(posedge clk); #1; t++; end
    bus.rdata_ready = 1'b0;

    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_blk = 13'h0003;
    @(posedge clk); #1;
    h = cyc;
    bus1.req_valid = 1'b0;
    bus1.rdata_ready = 1'b1;
    t = 0;
    while (!bus1.rdata_valid && t < 100) begin @(posedge clk); #1; t++; end
    checks++;
    if (!bus1.rdata_valid || cyc - h !== 1) begin
      $display("FAIL lat1_first_beat got %0d valid %b want 1", cyc - h, bus1.rdata_valid); errors++;
    end
    t = 0;
    while (bus1.busy && t < 100) begin @(posedge clk); #1; t++; end

    bus15.req_valid = 1'b1; bus15.req_write = 1'b0; bus15.req_blk = 13'h0003;
    @(posedge clk); #1;
    h = cyc;
    bus15.req_valid = 1'b0;
    bus15.rdata_ready = 1'b1;
    t = 0;
    while (!bus15.rdata_valid && t < 100) begin @(posedge clk); #1; t++; end
    checks++;
    if (!bus15.rdata_valid || cyc - h !== 15) begin
      $display("FAIL lat15_first_beat got %0d valid %b want 15", cyc - h, bus15.rdata_valid); errors++;
    end
    t = 0;
    while (bus15.busy && t < 100) begin @(posedge clk); #1; t++; end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;   bus.req_write = 1'b0;   bus.req_blk = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0;         bus.rdata_ready = 1'b0;
    bus1.req_valid = 1'b0;  bus1.req_write = 1'b0;  bus1.req_blk = '0;
    bus1.wdata_valid = 1'b0; bus1.wdata = '0;       bus1.rdata_ready = 1'b0;
    bus15.req_valid = 1'b0; bus15.req_write = 1'b0; bus15.req_blk = '0;
    bus15.wdata_valid = 1'b0; bus15.wdata = '0;     bus15.rdata_ready = 1'b0;

    test_reset();
    test_fill_after_reset();
    test_writeback_fill();
    test_backpressure_gaps();
    test_aliasing();
    test_reset_mid_write();
    test_ignored_and_lat();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
